// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the RX frame writer and the TX frame side.
//   rx_wr_state_e : states of the RX frame writer FSM
//   SYNC0_DEFAULT / SYNC1_DEFAULT : default 2-byte frame sync header
//   PULSE_LEN / PULSE_CNT_W : length and counter width of status pulses
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_REQ,
        SYNC_CHK,
        PIX_REQ,
        PIX_WAIT,
        PIX_WRITE,
        DONE,
        ERR
    } rx_wr_state_e;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

    // Status pulses (frame done / frame error) last this many cycles.
    localparam int PULSE_LEN   = 5;
    localparam int PULSE_CNT_W = 3;

endpackage

// File: rtl/uart_rx_frame_writer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_writer_if
// Bundles the RX FIFO read port and the frame buffer write port seen by the
// RX frame writer.
//   rx_empty  : FIFO empty
//   rd_en     : FIFO pop; rd_data is valid the following cycle
//   rd_data   : FIFO read data
//   fb_we     : frame buffer write enable
//   fb_wAddr  : frame buffer write address (0 when fb_we is low)
//   fb_wData  : frame buffer write data (0 when fb_we is low)
// Modports: master = frame writer, slave = FIFO / frame buffer side.
// -----------------------------------------------------------------------------
interface uart_rx_frame_writer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);

    logic                  rx_empty;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fb_we;
    logic [ADDR_WIDTH-1:0] fb_wAddr;
    logic [7:0]            fb_wData;

    modport master (
        input  rx_empty,
        input  rd_data,
        output rd_en,
        output fb_we,
        output fb_wAddr,
        output fb_wData
    );

    modport slave (
        output rx_empty,
        output rd_data,
        input  rd_en,
        input  fb_we,
        input  fb_wAddr,
        input  fb_wData
    );

endinterface

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns a single-cycle trigger into a level that is high for LEN cycles,
// starting the cycle after the trigger. A new trigger restarts the count.
//   clk       : clock
//   reset     : synchronous, active-high reset
//   i_trigger : start (or restart) the pulse
//   o_pulse   : stretched pulse output
// -----------------------------------------------------------------------------
module pulse_stretch
    import uart_pkg::*;
#(
    parameter int LEN = PULSE_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic i_trigger,
    output logic o_pulse
);

    logic [PULSE_CNT_W-1:0] r_cnt;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_trigger) begin
            r_cnt <= PULSE_CNT_W'(LEN);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PULSE_CNT_W'(1);
        end
    end

    assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/uart_rx_frame_writer.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_writer
// Pops bytes from the UART RX FIFO, hunts for the SYNC0/SYNC1 header and then
// writes IMG_WIDTH*IMG_HEIGHT pixel bytes to the frame buffer in raster order.
// An inter-byte timeout during pixel reception aborts a truncated upload.
//   clk             : clock
//   reset           : synchronous, active-high reset
//   i_rx_enable     : permits header hunting / new frame start
//   bus             : RX FIFO read port + frame buffer write port (master)
//   o_receiving     : high from header accepted until frame end or error
//   o_frame_rx_done : PULSE_LEN-cycle pulse after the last pixel is written
//   o_frame_rx_err  : PULSE_LEN-cycle pulse after a timeout abort
// -----------------------------------------------------------------------------
module uart_rx_frame_writer
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter int         IMG_WIDTH      = 176,
    parameter int         IMG_HEIGHT     = 240,
    parameter int         ADDR_WIDTH     = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter logic [7:0] SYNC0          = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1          = SYNC1_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rx_enable,
    uart_rx_frame_writer_if.master        bus,
    output logic                          o_receiving,
    output logic                          o_frame_rx_done,
    output logic                          o_frame_rx_err
);

    localparam int                    TOTAL    = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL - 1);
    localparam int                    TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    rx_wr_state_e          r_state,       w_state_next;
    logic                  r_sync_idx,    w_sync_idx_next;
    logic [ADDR_WIDTH-1:0] r_pixel_cnt,   w_pixel_cnt_next;
    logic [TO_W-1:0]       r_timeout_cnt, w_timeout_cnt_next;
    logic [7:0]            r_pixel_data,  w_pixel_data_next;

    logic                  w_rd_en;
    logic                  w_fb_we;
    logic [ADDR_WIDTH-1:0] w_fb_addr;
    logic [7:0]            w_fb_data;
    logic                  w_receiving;
    logic                  w_done_trig;
    logic                  w_err_trig;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [7:0]            w_rd_byte;

    // Only 8-bit FIFO words are supported; the pixel is the whole word.
    assign w_rd_word = bus.rd_data;
    assign w_rd_byte = w_rd_word[7:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sync_idx    <= 1'b0;
            r_pixel_cnt   <= '0;
            r_timeout_cnt <= '0;
            r_pixel_data  <= '0;
        end else begin
            r_state       <= w_state_next;
            r_sync_idx    <= w_sync_idx_next;
            r_pixel_cnt   <= w_pixel_cnt_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_pixel_data  <= w_pixel_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next       = r_state;
        w_sync_idx_next    = r_sync_idx;
        w_pixel_cnt_next   = r_pixel_cnt;
        w_timeout_cnt_next = r_timeout_cnt;
        w_pixel_data_next  = r_pixel_data;
        w_rd_en            = 1'b0;
        w_fb_we            = 1'b0;
        w_fb_addr          = '0;
        w_fb_data          = '0;
        w_receiving        = 1'b0;
        w_done_trig        = 1'b0;
        w_err_trig         = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_rx_enable) begin
                    w_sync_idx_next = 1'b0;
                    w_state_next    = SYNC_REQ;
                end
            end

            // Header hunting has no timeout; it may wait indefinitely.
            SYNC_REQ: begin
                if (!i_rx_enable) begin
                    w_state_next = IDLE;
                end else if (!bus.rx_empty) begin
                    w_rd_en      = 1'b1;
                    w_state_next = SYNC_CHK;
                end
            end

            // A SYNC0 seen while already holding SYNC0 keeps the match at
            // index 1, so a header preceded by extra SYNC0 bytes still locks.
            SYNC_CHK: begin
                w_state_next = SYNC_REQ;
                if (r_sync_idx && (w_rd_byte == SYNC1)) begin
                    w_pixel_cnt_next   = '0;
                    w_timeout_cnt_next = '0;
                    w_state_next       = PIX_REQ;
                end else if (w_rd_byte == SYNC0) begin
                    w_sync_idx_next = 1'b1;
                end else begin
                    w_sync_idx_next = 1'b0;
                end
            end

            PIX_REQ: begin
                w_receiving = 1'b1;
                if (!bus.rx_empty) begin
                    w_rd_en            = 1'b1;
                    w_timeout_cnt_next = '0;
                    w_state_next       = PIX_WAIT;
                end else if (r_timeout_cnt == TO_LAST) begin
                    w_state_next = ERR;
                end else begin
                    w_timeout_cnt_next = r_timeout_cnt + TO_W'(1);
                end
            end

            PIX_WAIT: begin
                w_receiving       = 1'b1;
                w_pixel_data_next = w_rd_byte;
                w_state_next      = PIX_WRITE;
            end

            PIX_WRITE: begin
                w_receiving = 1'b1;
                w_fb_we     = 1'b1;
                w_fb_addr   = r_pixel_cnt;
                w_fb_data   = r_pixel_data;
                if (r_pixel_cnt == LAST_PIX) begin
                    w_pixel_cnt_next = '0;
                    w_state_next     = DONE;
                end else begin
                    w_pixel_cnt_next = r_pixel_cnt + ADDR_WIDTH'(1);
                    w_state_next     = PIX_REQ;
                end
            end

            DONE: begin
                w_done_trig  = 1'b1;
                w_state_next = IDLE;
            end

            ERR: begin
                w_err_trig       = 1'b1;
                w_pixel_cnt_next = '0;
                w_state_next     = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.rd_en    = w_rd_en;
    assign bus.fb_we    = w_fb_we;
    assign bus.fb_wAddr = w_fb_addr;
    assign bus.fb_wData = w_fb_data;
    assign o_receiving  = w_receiving;

    // -------------------------------------------------------------------------
    // Status pulses; they count down independently of the FSM.
    // -------------------------------------------------------------------------
    pulse_stretch #(.LEN(PULSE_LEN)) u_done_pulse (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (w_done_trig),
        .o_pulse   (o_frame_rx_done)
    );

    pulse_stretch #(.LEN(PULSE_LEN)) u_err_pulse (
        .clk       (clk),
        .reset     (reset),
        .i_trigger (w_err_trig),
        .o_pulse   (o_frame_rx_err)
    );

endmodule
